// File: rtl/seq_alu_pkg.sv
// Shared opcode encoding and FSM state type for the multi-cycle ALU.
package seq_alu_pkg;

   localparam logic [3:0] OP_EQ  = 4'b0000;
   localparam logic [3:0] OP_GT  = 4'b0001;
   localparam logic [3:0] OP_LT  = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_DIV = 4'b0110;
   localparam logic [3:0] OP_SGT = 4'b0111;
   localparam logic [3:0] OP_SLT = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   // Divide by zero is resolved in one cycle, so it never enters the iterative path.
   function automatic logic is_iterative(input logic [3:0] op, input logic divisor_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle between the issuing stage and seq_alu.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_1;
   logic [WIDTH-1:0] operand_2;
   logic [3:0]       operator;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] answer1;
   logic [WIDTH-1:0] answer2;
   logic             div_by_zero;

   modport master (
      output in_valid, operand_1, operand_2, operator, out_ready,
      input  in_ready, out_valid, answer1, answer2, div_by_zero
   );

   modport slave (
      input  in_valid, operand_1, operand_2, operator, out_ready,
      output in_ready, out_valid, answer1, answer2, div_by_zero
   );
endinterface

// File: rtl/seq_alu_iter_unit.sv
// Shared shift-add multiplier / restoring divider, one step per clock.
// res_hi/res_lo present the post-step value so the caller can capture it on the final step edge.
module seq_alu_iter_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_is_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic             is_div;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem_shift, add_a, add_b;
   logic [WIDTH+1:0] sum;
   logic             busy;

   assign busy = (cnt != '0);
   assign done = (cnt == CNT_W'(1));

   // One adder serves both: mul adds the multiplicand, div subtracts the divisor (carry = no borrow).
   assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign add_a     = is_div ? rem_shift : {1'b0, acc_hi};
   assign add_b     = is_div ? ~{1'b0, opnd_b} : {1'b0, opnd_b};
   assign sum       = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};

   always_comb begin
      hi_nxt = acc_hi;
      lo_nxt = acc_lo;
      if (is_div) begin
         if (sum[WIDTH+1]) begin
            hi_nxt = sum[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = rem_shift[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (acc_lo[0]) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
         end else begin
            hi_nxt = {1'b0, acc_hi[WIDTH-1:1]};
            lo_nxt = {acc_hi[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   assign res_hi = hi_nxt;
   assign res_lo = lo_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi <= '0;
         acc_lo <= '0;
         opnd_b <= '0;
         is_div <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         acc_hi <= '0;
         acc_lo <= operand_a;
         opnd_b <= operand_b;
         is_div <= op_is_div;
         cnt    <= CNT_W'(WIDTH);
      end else if (busy) begin
         acc_hi <= hi_nxt;
         acc_lo <= lo_nxt;
         cnt    <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready request and result handshakes.
// Optional signed compares (opcodes 0111/1000) are enabled by defining SEQ_ALU_SIGNED_CMP_EN.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops resolve on the accept edge
// ITER  | mul / div stepping in the iteration unit
// DONE  | result valid, held until out_ready
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic      clk,
   input logic      rst_n,
   seq_alu_if.slave bus
);

   state_t           state, next_state;
   logic             start, load_single, load_iter, clr_dbz;
   logic             divisor_zero, go_iter;
   logic             iter_done;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [WIDTH-1:0] single_a1, single_a2;
   logic             single_dbz;
   logic [WIDTH-1:0] answer1_q, answer2_q;
   logic             dbz_q;

   assign divisor_zero = (bus.operand_2 == '0);
   assign go_iter      = is_iterative(bus.operator, divisor_zero);

   always_comb begin
      single_a1  = '0;
      single_a2  = '0;
      single_dbz = 1'b0;
      case (bus.operator)
         OP_EQ:  single_a1[0] = (bus.operand_1 == bus.operand_2);
         OP_GT:  single_a1[0] = (bus.operand_1 > bus.operand_2);
         OP_LT:  single_a1[0] = (bus.operand_1 < bus.operand_2);
         OP_ADD: {single_a2[0], single_a1} = {1'b0, bus.operand_1} + {1'b0, bus.operand_2};
         OP_SUB: begin
            single_a1    = bus.operand_1 - bus.operand_2;
            single_a2[0] = (bus.operand_1 < bus.operand_2);
         end
         OP_DIV: begin
            if (divisor_zero) begin
               single_a1  = '1;
               single_a2  = bus.operand_1;
               single_dbz = 1'b1;
            end
         end
`ifdef SEQ_ALU_SIGNED_CMP_EN
         OP_SGT: single_a1[0] = ($signed(bus.operand_1) > $signed(bus.operand_2));
         OP_SLT: single_a1[0] = ($signed(bus.operand_1) < $signed(bus.operand_2));
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      start       = 1'b0;
      load_single = 1'b0;
      load_iter   = 1'b0;
      clr_dbz     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (go_iter) begin
                  start      = 1'b1;
                  next_state = ITER;
               end else begin
                  load_single = 1'b1;
                  next_state  = DONE;
               end
            end
         end
         ITER: begin
            if (iter_done) begin
               load_iter  = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               clr_dbz    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   seq_alu_iter_unit #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_is_div (bus.operator == OP_DIV),
      .operand_a (bus.operand_1),
      .operand_b (bus.operand_2),
      .done      (iter_done),
      .res_hi    (iter_hi),
      .res_lo    (iter_lo)
   );

   // Answers persist after the handshake; only div_by_zero is cleared there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         answer1_q <= '0;
         answer2_q <= '0;
         dbz_q     <= 1'b0;
      end else if (load_single) begin
         answer1_q <= single_a1;
         answer2_q <= single_a2;
         dbz_q     <= single_dbz;
      end else if (load_iter) begin
         answer1_q <= iter_lo;
         answer2_q <= iter_hi;
         dbz_q     <= 1'b0;
      end else if (clr_dbz) begin
         dbz_q <= 1'b0;
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.answer1     = answer1_q;
   assign bus.answer2     = answer2_q;
   assign bus.div_by_zero = dbz_q;

endmodule
